syrup_mem1p_arbiter: RTL

- Shares one SyrupMemory1P port (1-cycle read latency) between NUM_REQ user-logic requesters.
- Round-robin arbitration with bounded burst hold.
- Registers the winning command onto the memory port.
- Routes read data back to the issuing requester using a tag pipeline.
- Sits between user-logic sub-blocks and a single SyrupMemory1P instance.

---
 rtl/syrup_mem1p_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/syrup_mem1p_arbiter.sv
// rtl/syrup_mem1p_arbiter.sv - round-robin arbiter sharing one SyrupMemory1P port among NUM_REQ requesters
// Define SYRUP_ARB_STAT_EN to add the STAT_GRANTS / STAT_CONFLICT counters.
module syrup_mem1p_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_REQ-1:0]                REQ,
  input  logic [NUM_REQ-1:0]                REQ_WE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     REQ_D,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] REQ_BE,
  output logic [NUM_REQ-1:0]                GNT,
  output logic [NUM_REQ-1:0]                RVALID,
  output logic [DATA_WIDTH-1:0]             RDATA,
  output logic [ADDR_WIDTH-1:0]             MEM_ADDR,
  output logic [DATA_WIDTH-1:0]             MEM_D,
  output logic [DATA_WIDTH/8-1:0]           MEM_BE,
  output logic                              MEM_WE,
  output logic                              MEM_RE,
  input  logic [DATA_WIDTH-1:0]             MEM_Q
`ifdef SYRUP_ARB_STAT_EN
  ,
  output logic [NUM_REQ*32-1:0]             STAT_GRANTS,
  output logic [31:0]                       STAT_CONFLICT
`endif
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW   = $clog2(MAX_BURST + 1) + 1;
  localparam int BEW  = DATA_WIDTH / 8;
  localparam int NSTG = 1 + MEM_LATENCY;

  logic              owner_valid_q, owner_valid_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]     gnt_idx;
  logic              accept;
  logic              holding;
  logic              owner_req;
  logic              others;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_d_q;
  logic [BEW-1:0]        mem_be_q;
  logic                  mem_we_q;
  logic                  mem_re_q;
  logic [NUM_REQ-1:0]    tag_q [NSTG];

  // Hold while the burst has budget; a lone owner restarts its burst instead of bubbling.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_idx   = '0;
    accept    = 1'b0;
    holding   = 1'b0;
    owner_req = owner_valid_q & REQ[owner_q];
    others    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (REQ[i] && (i != int'(owner_q))) others = 1'b1;
    end
    if (owner_req && (int'(burst_cnt_q) < MAX_BURST)) begin
      gnt_idx = owner_q;
      accept  = 1'b1;
      holding = 1'b1;
    end else if (owner_req && !others) begin
      gnt_idx = owner_q;
      accept  = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!accept && REQ[idx] && !(owner_valid_q && (idx == int'(owner_q)))) begin
          gnt_idx = IW'(idx);
          accept  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    GNT = '0;
    if (accept) GNT[gnt_idx] = 1'b1;
  end

  always_comb begin
    owner_valid_d = accept;
    owner_d       = accept ? gnt_idx : owner_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = '0;
    if (accept) begin
      rr_ptr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      burst_cnt_d = holding ? burst_cnt_q + 1'b1 : BW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      burst_cnt_q   <= '0;
      mem_addr_q    <= '0;
      mem_d_q       <= '0;
      mem_be_q      <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      mem_we_q      <= accept & REQ_WE[gnt_idx];
      mem_re_q      <= accept & ~REQ_WE[gnt_idx];
      if (accept) begin
        mem_addr_q <= REQ_ADDR[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_d_q    <= REQ_D[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        mem_be_q   <= REQ_BE[int'(gnt_idx)*BEW +: BEW];
      end
    end
  end

  // One-hot read tags track the command and memory stages so data returns to its issuer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < NSTG; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= (accept && !REQ_WE[gnt_idx]) ? GNT : '0;
      for (int s = 1; s < NSTG; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign RVALID   = tag_q[NSTG-1];
  assign RDATA    = MEM_Q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_D    = mem_d_q;
  assign MEM_BE   = mem_be_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_RE   = mem_re_q;

`ifdef SYRUP_ARB_STAT_EN
  logic [31:0] grants_q [NUM_REQ];
  logic [31:0] conflict_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
      conflict_q <= '0;
    end else begin
      if (accept) grants_q[gnt_idx] <= grants_q[gnt_idx] + 32'd1;
      if ($countones(REQ) >= 2) conflict_q <= conflict_q + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign STAT_GRANTS[i*32 +: 32] = grants_q[i];
  end
  assign STAT_CONFLICT = conflict_q;
`endif

endmodule
